// File: rtl/matmul_host.sv
// Host-side companion to the matmul engine: owns the Q8.8 operand memories,
// starts a multiply, and streams the engine's result vector out over valid/ready.
module matmul_host #(
    parameter int DATA1_LEN_BITS = 2,
    parameter int DATA2_COL_BITS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   ld_valid,
    output logic                                   ld_ready,
    input  logic                                   ld_target,
    input  logic [DATA1_LEN_BITS+DATA2_COL_BITS-1:0] ld_addr,
    input  logic [15:0]                            ld_data,
    input  logic                                   go,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   mm_start,
    input  logic                                   mm_ready,
    input  logic [DATA1_LEN_BITS-1:0]              mm_sel_vec,
    input  logic [DATA1_LEN_BITS-1:0]              mm_sel_row,
    input  logic [DATA2_COL_BITS-1:0]              mm_sel_col,
    output logic [15:0]                            mm_data1,
    output logic [15:0]                            mm_data2,
    output logic [DATA2_COL_BITS-1:0]              mm_sel,
    input  logic [15:0]                            mm_data_out,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [15:0]                            res_data,
    output logic [DATA2_COL_BITS-1:0]              res_idx,
    output logic                                   res_last
);

    localparam int VEC_LEN = 1 << DATA1_LEN_BITS;
    localparam int MAT_LEN = 1 << (DATA1_LEN_BITS + DATA2_COL_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ACK,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [DATA2_COL_BITS-1:0]   sel;
    logic [DATA2_COL_BITS-1:0]   sel_nxt;
    logic [15:0]                 vec_mem [VEC_LEN];
    logic [15:0]                 mat_mem [MAT_LEN];

    // Operand memories: written only while IDLE, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VEC_LEN; i++) vec_mem[i] <= '0;
            for (int i = 0; i < MAT_LEN; i++) mat_mem[i] <= '0;
        end else if (ld_valid && ld_ready) begin
            if (ld_target) mat_mem[ld_addr] <= ld_data;
            else           vec_mem[ld_addr[DATA1_LEN_BITS-1:0]] <= ld_data;
        end
    end

    assign mm_data1 = vec_mem[mm_sel_vec];
    assign mm_data2 = mat_mem[{mm_sel_row, mm_sel_col}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        mm_start  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        res_valid = 1'b0;
        ld_ready  = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                ld_ready = 1'b1;
                if (go) state_nxt = START;
            end
            START: begin
                mm_start  = 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                // Engine acknowledges the start by dropping ready.
                if (!mm_ready) state_nxt = RUN;
            end
            RUN: begin
                if (mm_ready) begin
                    state_nxt = DRAIN;
                    sel_nxt   = '0;
                end
            end
            DRAIN: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (&sel) state_nxt = DONE;
                    else      sel_nxt   = sel + 1'b1;
                end
            end
            DONE: begin
                done      = 1'b1;
                sel_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    assign mm_sel   = sel;
    assign res_data = mm_data_out;
    assign res_idx  = sel;
    assign res_last = res_valid && (&sel);

endmodule

// File: tb/tb_matmul_host.sv
// Bench for matmul_host: behavioural engine model, directed runs, and a
// queue-based scoreboard checked by an independent result monitor.
module tb_matmul_host;

    localparam int D1 = 2;
    localparam int D2 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_target;
    logic [D1+D2-1:0] ld_addr;
    logic [15:0]   ld_data;
    logic          go, busy, done, mm_start, mm_ready;
    logic [D1-1:0] mm_sel_vec, mm_sel_row;
    logic [D2-1:0] mm_sel_col, mm_sel, res_idx;
    logic [15:0]   mm_data1, mm_data2, mm_data_out, res_data;
    logic          res_valid, res_ready, res_last;

    always #5 clk = ~clk;

    matmul_host #(.DATA1_LEN_BITS(D1), .DATA2_COL_BITS(D2)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_target(ld_target),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .go(go), .busy(busy), .done(done),
        .mm_start(mm_start), .mm_ready(mm_ready),
        .mm_sel_vec(mm_sel_vec), .mm_sel_row(mm_sel_row), .mm_sel_col(mm_sel_col),
        .mm_data1(mm_data1), .mm_data2(mm_data2),
        .mm_sel(mm_sel), .mm_data_out(mm_data_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_idx(res_idx), .res_last(res_last)
    );

    // Engine model: one multiply-accumulate per cycle, row-major over columns.
    logic          probe_en;
    logic [D1-1:0] probe_vec, probe_row;
    logic [D2-1:0] probe_col;
    logic [D1-1:0] er;
    logic [D2-1:0] ec;
    logic          eng_busy;
    logic [15:0]   acc;
    logic [15:0]   eres [16];
    logic signed [31:0] prod_w;
    logic [15:0]   sum_w;

    assign mm_sel_vec  = probe_en ? probe_vec : er;
    assign mm_sel_row  = probe_en ? probe_row : er;
    assign mm_sel_col  = probe_en ? probe_col : ec;
    assign prod_w      = $signed(mm_data1) * $signed(mm_data2);
    assign sum_w       = acc + 16'(prod_w >>> 8);
    assign mm_data_out = eres[mm_sel];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mm_ready <= 1'b1;
            eng_busy <= 1'b0;
            er       <= '0;
            ec       <= '0;
            acc      <= '0;
            for (int i = 0; i < 16; i++) eres[i] <= '0;
        end else if (mm_start && !eng_busy) begin
            mm_ready <= 1'b0;
            eng_busy <= 1'b1;
            er       <= '0;
            ec       <= '0;
            acc      <= '0;
        end else if (eng_busy) begin
            if (er == 2'd3) begin
                eres[ec] <= sum_w;
                acc      <= '0;
                er       <= '0;
                if (ec == 4'd15) begin
                    eng_busy <= 1'b0;
                    mm_ready <= 1'b1;
                end else begin
                    ec <= ec + 1'b1;
                end
            end else begin
                acc <= sum_w;
                er  <= er + 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: pops one expectation per accepted result word.
    initial begin : monitor
        exp_t        e;
        logic        done_due;
        logic        stall_prev;
        logic [15:0] prev_data;
        logic [3:0]  prev_idx;
        done_due   = 1'b0;
        stall_prev = 1'b0;
        prev_data  = '0;
        prev_idx   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_due   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (done_due) begin
                    check("done_after_last", done, 1);
                    done_due = 1'b0;
                end
                if (stall_prev && res_valid) begin
                    check("stall_data", res_data, prev_data);
                    check("stall_idx", res_idx, prev_idx);
                end
                if (res_valid && res_ready) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        e = q.pop_front();
                        check("res_data", res_data, e.d);
                        check("res_idx", res_idx, e.idx);
                        check("res_last", res_last, e.last);
                        if (e.last) done_due = 1'b1;
                    end
                end
                stall_prev = res_valid && !res_ready;
                prev_data  = res_data;
                prev_idx   = res_idx;
            end
        end
    end

    task automatic push_exp(input int kind);
        logic [15:0] d;
        for (int c = 0; c < 16; c++) begin
            case (kind)
                0:       d = (c < 4) ? 16'((c + 1) << 8) : 16'h0000;
                1:       d = 16'hFFFC;
                default: d = 16'h0000;
            endcase
            q.push_back('{d: d, idx: 4'(c), last: (c == 15)});
        end
    endtask

    task automatic load(input logic tgt, input logic [D1+D2-1:0] addr, input logic [15:0] data);
        ld_valid  = 1'b1;
        ld_target = tgt;
        ld_addr   = addr;
        ld_data   = data;
        @(posedge clk);
        #1;
        ld_valid  = 1'b0;
    endtask

    task automatic probe_vec_mem(input string name, input logic [15:0] exp);
        probe_en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            probe_vec = 2'(v);
            #1;
            check(name, mm_data1, exp);
        end
        probe_en = 1'b0;
    endtask

    // mode 0: ready always; 1: ready one cycle in three; 2: reset while idx 5 is presented.
    task automatic run(input int mode, input bit midload);
        int starts = 0;
        int dones  = 0;
        int cyc    = 0;
        bit fin    = 0;
        bit hit5   = 0;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        while (!fin && cyc < 600) begin
            case (mode)
                0:       res_ready = 1'b1;
                1:       res_ready = (cyc % 3 == 0);
                default: res_ready = !(res_valid && res_idx == 4'd5);
            endcase
            if (midload && cyc == 5) begin
                ld_valid  = 1'b1;
                ld_target = 1'b0;
                ld_addr   = '0;
                ld_data   = 16'hFFFF;
            end
            if (midload && cyc == 8) ld_valid = 1'b0;
            @(negedge clk);
            if (mm_start) starts++;
            if (done) begin
                dones++;
                fin = 1;
            end
            if (midload && cyc == 5) check("ld_ready_in_run", ld_ready, 0);
            if (mode == 2 && res_valid && res_idx == 4'd5 && !res_ready) begin
                #2;
                rst = 1'b1;
                #1;
                check("rst_res_valid", res_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_ld_ready", ld_ready, 1);
                check("rst_res_idx", res_idx, 0);
                probe_vec_mem("rst_vec_cleared", 16'h0000);
                probe_en  = 1'b1;
                probe_row = 2'd1;
                probe_col = 4'd1;
                #1;
                check("rst_mat_cleared", mm_data2, 16'h0000);
                probe_en  = 1'b0;
                q.delete();
                hit5 = 1;
                fin  = 1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        res_ready = 1'b0;
        if (mode == 2) begin
            if (!hit5) fail_now("timeout_reaching_idx5");
            rst = 1'b0;
        end else begin
            if (!fin) fail_now("timeout_waiting_done");
            check("mm_start_cycles", starts, 1);
            check("done_cycles", dones, 1);
            check("queue_drained", q.size(), 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_target = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        go        = 1'b0;
        res_ready = 1'b0;
        probe_en  = 1'b0;
        probe_vec = '0;
        probe_row = '0;
        probe_col = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_ld_ready", ld_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_mm_start", mm_start, 0);
        check("reset_done", done, 0);
        probe_vec_mem("reset_vec", 16'h0000);
        probe_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) begin
                probe_row = 2'(r);
                probe_col = 4'(c);
                #1;
                check("reset_mat", mm_data2, 16'h0000);
            end
        end
        probe_en = 1'b0;
        @(posedge clk);
        #1;

        // Identity weights
        for (int r = 0; r < 4; r++) load(1'b0, 6'(r), 16'((r + 1) << 8));
        for (int r = 0; r < 4; r++) load(1'b1, 6'((r << 4) | r), 16'h0100);
        push_exp(0);
        run(0, 1'b0);

        // Back-pressure, same operands
        push_exp(0);
        run(1, 1'b0);

        // Load attempt during RUN must not land
        push_exp(0);
        run(0, 1'b1);
        probe_en  = 1'b1;
        probe_vec = 2'd0;
        #1;
        check("vec0_after_blocked_load", mm_data1, 16'h0100);
        probe_en  = 1'b0;

        // Accumulator wrap
        for (int r = 0; r < 4; r++) load(1'b0, 6'(r), 16'h7FFF);
        for (int a = 0; a < 64; a++) load(1'b1, 6'(a), 16'h0100);
        push_exp(1);
        run(0, 1'b0);

        // Reset mid-DRAIN, then rerun from cleared memories
        push_exp(1);
        run(2, 1'b0);
        push_exp(2);
        run(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
